// File: rtl/err_tlm_framer.sv
// Snapshots the error counter bank and streams it as a framed byte stream.
// Define ERR_TLM_CRC8_EN to replace the additive checksum with CRC-8 (0x07).
module err_tlm_framer #(
    parameter int          N_CNT = 11,
    parameter logic [7:0]  HDR0  = 8'hEB,
    parameter logic [7:0]  HDR1  = 8'h90
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    input  logic [8*N_CNT-1:0]   sums_in,
    input  logic                 tx_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    output logic                 busy,
    output logic                 frame_done,
    output logic [7:0]           drop_cnt
);

    localparam int IW = (N_CNT > 1) ? $clog2(N_CNT) : 1;
    localparam logic [IW-1:0] LAST = IW'(N_CNT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR0, S_HDR1, S_SEQ, S_DATA, S_CHK
    } state_t;

    state_t                     state_q, state_d;
    logic [N_CNT-1:0][7:0]      snap_q;
    logic [IW-1:0]              idx_q;
    logic [7:0]                 seq_q;
    logic [7:0]                 chk_q;
    logic                       pending_q;
    logic [7:0]                 drop_q;
    logic                       done_q;
    logic                       start;

    function automatic logic [7:0] chk_step(input logic [7:0] c,
                                            input logic [7:0] b);
`ifdef ERR_TLM_CRC8_EN
        logic [7:0] r;
        r = c ^ b;
        for (int i = 0; i < 8; i++)
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
`else
        return c + b;
`endif
    endfunction

    assign start = (state_q == S_IDLE) && (req || pending_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (req || pending_q) state_d = S_HDR0;
            S_HDR0: if (tx_ready) state_d = S_HDR1;
            S_HDR1: if (tx_ready) state_d = S_SEQ;
            S_SEQ:  if (tx_ready) state_d = S_DATA;
            S_DATA: if (tx_ready && idx_q == LAST) state_d = S_CHK;
            S_CHK:  if (tx_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_valid = (state_q != S_IDLE);
        busy     = (state_q != S_IDLE);
        tx_data  = 8'h00;
        unique case (state_q)
            S_HDR0:  tx_data = HDR0;
            S_HDR1:  tx_data = HDR1;
            S_SEQ:   tx_data = seq_q;
            S_DATA:  tx_data = snap_q[idx_q];
            S_CHK:   tx_data = chk_q;
            default: tx_data = 8'h00;
        endcase
    end

    assign frame_done = done_q;
    assign drop_cnt   = drop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q    <= '0;
            idx_q     <= '0;
            seq_q     <= '0;
            chk_q     <= '0;
            pending_q <= 1'b0;
            drop_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state_q == S_CHK) && tx_ready;
            if (start) begin
                snap_q <= sums_in;
                idx_q  <= '0;
                chk_q  <= '0;
            end
            if (state_q == S_SEQ && tx_ready)
                chk_q <= chk_step(chk_q, seq_q);
            if (state_q == S_DATA && tx_ready) begin
                chk_q <= chk_step(chk_q, snap_q[idx_q]);
                idx_q <= idx_q + 1'b1;
            end
            if (state_q == S_CHK && tx_ready)
                seq_q <= seq_q + 8'd1;
            // A request arriving with a pending one already served keeps pending set
            if (state_q == S_IDLE) begin
                if (req || pending_q)
                    pending_q <= req && pending_q;
            end else if (req) begin
                if (!pending_q)
                    pending_q <= 1'b1;
                else if (drop_q != 8'hFF)
                    drop_q <= drop_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_err_tlm_framer.sv
// Directed bench for err_tlm_framer with a frame-level reference model.
// Define ERR_TLM_CRC8_EN here too when building the CRC variant.
module tb_err_tlm_framer;

    localparam int N = 11;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           req = 1'b0;
    logic [8*N-1:0] sums_in = '0;
    logic           tx_ready = 1'b0;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           busy;
    logic           frame_done;
    logic [7:0]     drop_cnt;

    err_tlm_framer dut (
        .clk(clk), .rst_n(rst_n), .req(req), .sums_in(sums_in),
        .tx_ready(tx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
        .busy(busy), .frame_done(frame_done), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: queue of bytes the DUT must emit, in order
    logic [7:0] exp_q[$];
    bit         last_q[$];
    logic [7:0] seq_m = 8'h00;

    function automatic logic [7:0] frame_chk(input logic [7:0] msg[$]);
        logic [7:0] c;
        c = 8'h00;
`ifdef ERR_TLM_CRC8_EN
        foreach (msg[i])
            for (int b = 7; b >= 0; b--) begin
                logic fb;
                fb = c[7] ^ msg[i][b];
                c = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h07;
            end
`else
        foreach (msg[i]) c = c + msg[i];
`endif
        return c;
    endfunction

    task automatic push_frame(input logic [8*N-1:0] s);
        logic [7:0] msg[$];
        msg.push_back(seq_m);
        for (int k = 0; k < N; k++) msg.push_back(s[8*k +: 8]);
        exp_q.push_back(8'hEB); last_q.push_back(1'b0);
        exp_q.push_back(8'h90); last_q.push_back(1'b0);
        foreach (msg[i]) begin
            exp_q.push_back(msg[i]); last_q.push_back(1'b0);
        end
        exp_q.push_back(frame_chk(msg)); last_q.push_back(1'b1);
        seq_m = seq_m + 8'd1;
    endtask

    // Compare process
    logic [7:0] cap[$];
    logic [7:0] held;
    logic [7:0] last_seq = 8'h00;
    logic [7:0] last_chk = 8'h00;
    bit         stall_p = 1'b0;
    bit         done_exp = 1'b0;
    int         pos = 0;
    int         nframes = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_p  = 1'b0;
            done_exp = 1'b0;
            pos      = 0;
        end else begin
            chk("frame_done", frame_done, done_exp);
            if (stall_p) chk("hold", {tx_valid, tx_data}, {1'b1, held});
            done_exp = 1'b0;
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL extra_byte: got %0h expected none", tx_data);
                end else begin
                    logic [7:0] e;
                    bit l;
                    e = exp_q.pop_front();
                    l = last_q.pop_front();
                    chk("byte", tx_data, e);
                    cap.push_back(tx_data);
                    if (pos == 2) last_seq = tx_data;
                    pos++;
                    if (l) begin
                        chk("frame_len", pos, N + 4);
                        pos = 0;
                        last_chk = tx_data;
                        done_exp = 1'b1;
                        nframes++;
                    end
                end
            end
            stall_p = tx_valid && !tx_ready;
            held = tx_data;
        end
    end

    // tx_ready generator: 0 = always ready, 1 = random, 2 = stalled
    int rmode = 0;
    always @(posedge clk) begin
        #2;
        case (rmode)
            0: tx_ready = 1'b1;
            1: tx_ready = 1'($urandom_range(0, 1));
            default: tx_ready = 1'b0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_req();
        tick();
        req = 1'b1;
        tick();
        req = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            checks++;
            $display("FAIL drain_timeout: got %0d left expected 0", exp_q.size());
        end
        tick();
        tick();
    endtask

    task automatic do_reset();
        tick();
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        last_q.delete();
        seq_m = 8'h00;
        tick();
        rst_n = 1'b1;
    endtask

    logic [8*N-1:0] sa, sb;
    logic [7:0]     lit1[15];
    int             n0, n;

    initial begin
        for (int k = 0; k < N; k++) begin
            sa[8*k +: 8] = 8'(k + 1);
            sb[8*k +: 8] = 8'(8'h10 + k);
        end
        lit1 = '{8'hEB, 8'h90, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h42};

        // Reset values
        #1;
        chk("rst_valid", tx_valid, 1'b0);
        chk("rst_data", tx_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_drop", drop_cnt, 8'h00);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // 1: basic frame, back-to-back
        rmode = 0;
        sums_in = sa;
        push_frame(sa);
        cap.delete();
        pulse_req();
        chk("latency", {tx_valid, tx_data}, {1'b1, 8'hEB});
        wait_drain(100);
        chk("t1_len", cap.size(), 15);
        for (int i = 0; i < 15; i++)
            if (i < cap.size()) chk("t1_lit", cap[i], lit1[i]);

        // 2: stall on data byte 3, then random ready
        cap.delete();
        push_frame(sa);
        pulse_req();
        n = 0;
        while (!(tx_valid && tx_data == 8'h04) && n < 40) begin
            tick();
            n++;
        end
        chk("t2_found", n < 40, 1'b1);
        rmode = 2;
        repeat (5) tick();
        rmode = 1;
        wait_drain(300);
        rmode = 0;
        tick();
        chk("t2_len", cap.size(), 15);
        chk("t2_seq", last_seq, 8'h01);

        // 3: sums change mid-frame are invisible
        push_frame(sa);
        pulse_req();
        repeat (6) tick();
        sums_in = '1;
        wait_drain(100);
`ifndef ERR_TLM_CRC8_EN
        chk("t3_chk", last_chk, 8'h44);
`endif

        // 4: pending plus one drop
        sums_in = sa;
        push_frame(sa);
        pulse_req();
        repeat (3) tick();
        sums_in = sb;
        pulse_req();
        pulse_req();
        push_frame(sb);
        n0 = nframes;
        n = 0;
        while (nframes == n0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        tick();
        chk("t4_gap_valid", tx_valid, 1'b0);
        chk("t4_gap_done", frame_done, 1'b1);
        tick();
        chk("t4_restart", {tx_valid, tx_data}, {1'b1, 8'hEB});
        repeat (6) tick();
        sums_in = {N{8'h55}};
        wait_drain(100);
        chk("t4_seq", last_seq, 8'h04);
        chk("t4_drop", drop_cnt, 8'h01);

        // 5: reset mid-data
        sums_in = sa;
        push_frame(sa);
        pulse_req();
        repeat (6) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t5_valid", tx_valid, 1'b0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_drop", drop_cnt, 8'h00);
        exp_q.delete();
        last_q.delete();
        seq_m = 8'h00;
        tick();
        rst_n = 1'b1;
        push_frame(sa);
        pulse_req();
        wait_drain(100);
        chk("t5_seq", last_seq, 8'h00);

        // Sequence wrap
        for (int f = 1; f < 256; f++) begin
            push_frame(sa);
            pulse_req();
            wait_drain(100);
        end
        chk("wrap_ff", last_seq, 8'hFF);
        push_frame(sa);
        pulse_req();
        wait_drain(100);
        chk("wrap_00", last_seq, 8'h00);

        // drop_cnt saturation while stalled
        rmode = 2;
        push_frame(sa);
        pulse_req();
        repeat (258) pulse_req();
        chk("sat_drop", drop_cnt, 8'hFF);
        push_frame(sa);
        rmode = 0;
        wait_drain(200);
        chk("sat_hold", drop_cnt, 8'hFF);

        // Checksum of a single 0x01 at byte 10
        do_reset();
        sums_in = '0;
        sums_in[8*10 +: 8] = 8'h01;
        push_frame(sums_in);
        pulse_req();
        wait_drain(100);
`ifdef ERR_TLM_CRC8_EN
        chk("crc_lit", last_chk, 8'h07);
`else
        chk("sum_lit", last_chk, 8'h01);
`endif
        chk("end_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
